// File: rtl/ddio_in.sv
// Double-data-rate input capture for the ADC LVDS lanes: each lane is sampled on both
// inclock edges and presented as a rising/falling word pair. Optional macro DDIO_OUTREG_EN adds an output stage.
module ddio_in #(
    parameter int unsigned WIDTH   = 8,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic             inclock,
    input  logic             aclr,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout_h,
    output logic [WIDTH-1:0] dataout_l
);

    localparam logic [WIDTH-1:0] RST_WORD = {WIDTH{RST_VAL}};

    logic [WIDTH-1:0] cap_l;
    logic [WIDTH-1:0] pair_h;
    logic [WIDTH-1:0] pair_l;

    always_ff @(negedge inclock or posedge aclr) begin
        if (aclr) begin
            cap_l <= RST_WORD;
        end else begin
            cap_l <= datain;
        end
    end

    // The falling sample is the older bit of the pair; both words move together on the rise.
    always_ff @(posedge inclock or posedge aclr) begin
        if (aclr) begin
            pair_h <= RST_WORD;
            pair_l <= RST_WORD;
        end else begin
            pair_h <= datain;
            pair_l <= cap_l;
        end
    end

`ifdef DDIO_OUTREG_EN
    always_ff @(posedge inclock or posedge aclr) begin
        if (aclr) begin
            dataout_h <= RST_WORD;
            dataout_l <= RST_WORD;
        end else begin
            dataout_h <= pair_h;
            dataout_l <= pair_l;
        end
    end
`else
    assign dataout_h = pair_h;
    assign dataout_l = pair_l;
`endif

endmodule

// File: tb/tb_ddio_in.sv
// Directed self-checking bench for ddio_in; honours DDIO_OUTREG_EN by expecting each
// rising-edge pair one inclock cycle later.
module tb_ddio_in;

    logic       inclock;
    logic       aclr;
    logic [7:0] datain;
    logic [7:0] dataout_h;
    logic [7:0] dataout_l;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [7:0] pend_h;
    logic [7:0] pend_l;

    logic [11:0] frame [8] = '{12'hA5C, 12'h3F0, 12'h81E, 12'hFFF,
                               12'h000, 12'h5A5, 12'hC39, 12'h6D2};
    logic [11:0] asm_w [8];

    ddio_in #(.WIDTH(8), .RST_VAL(1'b0)) dut (
        .inclock   (inclock),
        .aclr      (aclr),
        .datain    (datain),
        .dataout_h (dataout_h),
        .dataout_l (dataout_l)
    );

    initial inclock = 1'b0;
    always #5 inclock = ~inclock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected pair right after a rising edge, in no-outreg terms; the outreg build sees it one rise later.
    task automatic expect_rise(input string tag, input logic [7:0] eh, input logic [7:0] el);
`ifdef DDIO_OUTREG_EN
        check({tag, "_h"}, {8'h00, dataout_h}, {8'h00, pend_h});
        check({tag, "_l"}, {8'h00, dataout_l}, {8'h00, pend_l});
        pend_h = eh;
        pend_l = el;
`else
        check({tag, "_h"}, {8'h00, dataout_h}, {8'h00, eh});
        check({tag, "_l"}, {8'h00, dataout_l}, {8'h00, el});
`endif
    endtask

    // Called just after a rise: drive fv for the fall, rv for the next rise, return 1 after that rise.
    task automatic cycle(input logic [7:0] fv, input logic [7:0] rv);
        datain = fv;
        @(negedge inclock);
        #2 datain = rv;
        @(posedge inclock);
        #1;
    endtask

    task automatic assert_reset();
        aclr   = 1'b1;
        pend_h = 8'h00;
        pend_l = 8'h00;
    endtask

    function automatic logic [7:0] slot(input int unsigned b);
        logic [7:0] r;
        for (int unsigned i = 0; i < 8; i++) r[i] = frame[i][b];
        return r;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        datain   = 8'hFF;
        assert_reset();

        // 1: reset held, clock edges ignored
        for (int i = 0; i < 3; i++) begin
            @(posedge inclock);
            #1 check("rst_rise", {dataout_h, dataout_l}, 16'h0000);
            @(negedge inclock);
            #1 check("rst_fall", {dataout_h, dataout_l}, 16'h0000);
        end

        // 2: release while clock low; first rise has no post-release fall, so l stays reset
        #1 aclr = 1'b0;
        datain = 8'h3C;
        @(posedge inclock);
        #1 expect_rise("rel_first", 8'h3C, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cycle(8'hA5, 8'h3C);
            expect_rise("a5_3c", 8'h3C, 8'hA5);
        end

        // asynchronous clear between edges
        #1 assert_reset();
        #1 check("async_clr", {dataout_h, dataout_l}, 16'h0000);

        // 3: walking one on lane 3 at the fall only
        @(negedge inclock);
        #2 aclr = 1'b0;
        datain = 8'h00;
        @(posedge inclock);
        #1 expect_rise("walk_pre", 8'h00, 8'h00);
        cycle(8'h08, 8'h00);
        expect_rise("walk_one", 8'h00, 8'h08);
        cycle(8'h00, 8'h00);
        expect_rise("walk_post", 8'h00, 8'h00);
        cycle(8'h00, 8'h00);
        expect_rise("walk_flush", 8'h00, 8'h00);

        // 4: release while clock high
        #1 assert_reset();
        datain = 8'hFF;
        @(posedge inclock);
        #1 datain = 8'h00;
        aclr = 1'b0;
        @(negedge inclock);
        #2 datain = 8'h5A;
        @(posedge inclock);
        #1 expect_rise("hi_rel_first", 8'h5A, 8'h00);
        cycle(8'hC3, 8'h96);
        expect_rise("hi_rel_next", 8'h96, 8'hC3);

        // 5: 12-bit frame per lane, MSB first, falling (older) bit then rising bit
        for (int unsigned i = 0; i < 8; i++) asm_w[i] = '0;
`ifdef DDIO_OUTREG_EN
        for (int unsigned k = 0; k < 7; k++) begin
            if (k < 6) cycle(slot(11 - 2 * k), slot(10 - 2 * k));
            else       cycle(8'h00, 8'h00);
            if (k >= 1)
                for (int unsigned i = 0; i < 8; i++)
                    asm_w[i] = {asm_w[i][9:0], dataout_l[i], dataout_h[i]};
        end
`else
        for (int unsigned k = 0; k < 6; k++) begin
            cycle(slot(11 - 2 * k), slot(10 - 2 * k));
            for (int unsigned i = 0; i < 8; i++)
                asm_w[i] = {asm_w[i][9:0], dataout_l[i], dataout_h[i]};
        end
`endif
        for (int unsigned i = 0; i < 8; i++)
            check($sformatf("frame_lane%0d", i), {4'h0, asm_w[i]}, {4'h0, frame[i]});

        // reset mid-stream discards the in-flight pair
        datain = 8'hE7;
        @(negedge inclock);
        #1 assert_reset();
        #1 check("mid_clr", {dataout_h, dataout_l}, 16'h0000);
        @(posedge inclock);
        #1 check("mid_hold", {dataout_h, dataout_l}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
